// File: rtl/sw_ctrl_pkg.sv
// Shared encodings for the push-switch front end: mode select and switch polarity.
package sw_ctrl_pkg;

    localparam logic SW_MODE_TOGGLE    = 1'b0;
    localparam logic SW_MODE_MOMENTARY = 1'b1;
    localparam logic SW_PRESSED        = 1'b0;
    localparam logic SW_RELEASED       = 1'b1;

endpackage

// File: rtl/sw_toggle_ctrl_if.sv
// Switch/LED bundle between the board-side driver and sw_toggle_ctrl.
interface sw_toggle_ctrl_if #(
    parameter int NUM_CH = 4
);

    logic [NUM_CH-1:0] i_sw_n;
    logic [NUM_CH-1:0] i_mode;
    logic              i_clear;
    logic [NUM_CH-1:0] o_led;
    logic [NUM_CH-1:0] o_press_pulse;
    logic [NUM_CH-1:0] o_release_pulse;
    logic [NUM_CH-1:0] o_long_pulse;

    modport master (
        output i_sw_n, i_mode, i_clear,
        input  o_led, o_press_pulse, o_release_pulse, o_long_pulse
    );

    modport slave (
        input  i_sw_n, i_mode, i_clear,
        output o_led, o_press_pulse, o_release_pulse, o_long_pulse
    );

endinterface

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop sync, debounce counter, stable level and registered edge pulses.
// Stable level moves DEBOUNCE_CYCLES+1 edges after a new level is first sampled; pulses one edge later.
module sw_debounce
    import sw_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 270000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw_n,
    output logic o_stable,
    output logic o_press_evt,
    output logic o_press_pulse,
    output logic o_release_pulse
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;
    logic          release_evt;

    assign o_press_evt = (stable_d == SW_RELEASED) && (stable == SW_PRESSED);
    assign release_evt = (stable_d == SW_PRESSED) && (stable == SW_RELEASED);
    assign o_stable    = stable;

    // Everything resets to "released" so a switch held through reset is seen as a fresh press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync1           <= SW_RELEASED;
            sync2           <= SW_RELEASED;
            stable          <= SW_RELEASED;
            stable_d        <= SW_RELEASED;
            cnt             <= '0;
            o_press_pulse   <= 1'b0;
            o_release_pulse <= 1'b0;
        end else begin
            sync1    <= i_sw_n;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            o_press_pulse   <= o_press_evt;
            o_release_pulse <= release_evt;
        end
    end

endmodule

// File: rtl/sw_toggle_ctrl.sv
// N-channel push-switch front end: debounced press/release pulses, per-channel TOGGLE/MOMENTARY LED.
// Optional long-press detection is built when SW_LONG_PRESS_EN is defined.
module sw_toggle_ctrl
    import sw_ctrl_pkg::*;
#(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int LONG_CYCLES     = 27000000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    sw_toggle_ctrl_if.slave bus
);

    if (NUM_CH < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 2) begin : g_param_check
        $error("sw_toggle_ctrl: illegal parameter value");
    end

    logic [NUM_CH-1:0] stable;
    logic [NUM_CH-1:0] press_evt;
    logic [NUM_CH-1:0] toggle_q;
    logic [NUM_CH-1:0] toggle_d;
    logic [NUM_CH-1:0] led_d;
    logic [NUM_CH-1:0] led_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        sw_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_clk           (i_clk),
            .i_rst           (i_rst),
            .i_sw_n          (bus.i_sw_n[g]),
            .o_stable        (stable[g]),
            .o_press_evt     (press_evt[g]),
            .o_press_pulse   (bus.o_press_pulse[g]),
            .o_release_pulse (bus.o_release_pulse[g])
        );
    end

    // Toggle flips on the same edge the press pulse registers; clear has priority.
    always_comb begin
        toggle_d = toggle_q;
        led_d    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.i_clear) begin
                toggle_d[i] = 1'b0;
            end else if (press_evt[i] && (bus.i_mode[i] == SW_MODE_TOGGLE)) begin
                toggle_d[i] = ~toggle_q[i];
            end
            led_d[i] = (bus.i_mode[i] == SW_MODE_TOGGLE) ? toggle_d[i]
                                                         : (stable[i] == SW_PRESSED);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            toggle_q <= '0;
            led_q    <= '0;
        end else begin
            toggle_q <= toggle_d;
            led_q    <= led_d;
        end
    end

    assign bus.o_led = led_q;

`ifdef SW_LONG_PRESS_EN
    localparam int            LW        = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

    logic [LW-1:0]     long_cnt [NUM_CH];
    logic [NUM_CH-1:0] long_q;

    // Counter parks at LONG_CYCLES so the pulse fires once per press.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                long_cnt[i] <= '0;
            end
            long_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                long_q[i] <= 1'b0;
                if (press_evt[i]) begin
                    long_cnt[i] <= '0;
                end else if (stable[i] == SW_PRESSED) begin
                    if (long_cnt[i] == LONG_LAST) begin
                        long_q[i] <= 1'b1;
                    end
                    if (long_cnt[i] != LONG_SAT) begin
                        long_cnt[i] <= long_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_long_pulse = long_q;
`else
    assign bus.o_long_pulse = '0;
`endif

endmodule

// File: tb/tb_sw_toggle_ctrl.sv
// Directed bench for sw_toggle_ctrl with NUM_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_sw_toggle_ctrl;

`ifdef SW_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sw_toggle_ctrl_if #(.NUM_CH(4)) bus ();

    sw_toggle_ctrl #(
        .NUM_CH          (4),
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [15:0] all_out();
        return {bus.o_led, bus.o_press_pulse, bus.o_release_pulse, bus.o_long_pulse};
    endfunction

    // Holds ch1 low for len edges, then counts ch1 pulses over a 20-edge window.
    task automatic run_glitch(input int len, output int np, output int nr);
        np = 0;
        nr = 0;
        bus.i_sw_n[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == len) bus.i_sw_n[1] = 1'b1;
            tick();
            np += int'(bus.o_press_pulse[1]);
            nr += int'(bus.o_release_pulse[1]);
        end
    endtask

    initial begin
        int np, nr;
        bus.i_sw_n  = 4'hF;
        bus.i_mode  = 4'h0;
        bus.i_clear = 1'b0;

        // 1: reset state and quiet idle
        repeat (3) tick();
        check_eq("reset_outputs", all_out(), 16'h0);
        i_rst = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            check_eq("idle_outputs", all_out(), 16'h0);
        end

        // 2: ch0 toggle press, release, second press
        bus.i_sw_n = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t2_press_pulse", bus.o_press_pulse, (k == 6) ? 4'b0001 : 4'b0000);
            check_eq("t2_led_on", bus.o_led, (k >= 6) ? 4'b0001 : 4'b0000);
        end
        bus.i_sw_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t2_release_pulse", bus.o_release_pulse, (k == 6) ? 4'b0001 : 4'b0000);
            check_eq("t2_led_hold", bus.o_led, 4'b0001);
        end
        bus.i_sw_n = 4'b1110;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t2_led_off", bus.o_led, (k >= 6) ? 4'b0000 : 4'b0001);
        end
        bus.i_sw_n = 4'hF;
        repeat (10) tick();

        // 3: glitch shorter than debounce is ignored; exactly debounce length is accepted
        run_glitch(3, np, nr);
        check_eq("t3_glitch_press", np, 0);
        check_eq("t3_glitch_release", nr, 0);
        check_eq("t3_glitch_led", bus.o_led, 4'b0000);
        run_glitch(4, np, nr);
        check_eq("t3_min_press", np, 1);
        check_eq("t3_min_release", nr, 1);
        check_eq("t3_min_led", bus.o_led, 4'b0010);

        // 3b: async reset mid-bounce on ch2
        bus.i_sw_n = 4'b1011;
        tick();
        tick();
        #2 i_rst = 1'b1;
        #1 check_eq("t3_async_reset", all_out(), 16'h0);
        tick();
        bus.i_sw_n = 4'hF;
        tick();
        i_rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("t3_after_reset", all_out(), 16'h0);
        end

        // 4: ch2 momentary
        bus.i_mode = 4'b0100;
        bus.i_sw_n = 4'b1011;
        for (int k = 0; k < 12; k++) begin
            tick();
            check_eq("t4_mom_press", bus.o_led, (k >= 6) ? 4'b0100 : 4'b0000);
        end
        bus.i_sw_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t4_mom_release", bus.o_led, (k < 6) ? 4'b0100 : 4'b0000);
        end
        bus.i_mode = 4'b0000;
        tick();
        check_eq("t4_back_to_toggle", bus.o_led, 4'b0000);

        // 5: clear beats a simultaneous flip, then plain toggle, then clear alone
        bus.i_sw_n = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            bus.i_clear = (k == 6);
            tick();
            if (k == 6) begin
                check_eq("t5_clear_press_pulse", bus.o_press_pulse, 4'b1000);
                check_eq("t5_clear_wins", bus.o_led, 4'b0000);
            end
        end
        bus.i_clear = 1'b0;
        bus.i_sw_n  = 4'hF;
        repeat (10) tick();
        bus.i_sw_n = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t5_ch3_toggle", bus.o_led, (k >= 6) ? 4'b1000 : 4'b0000);
        end
        bus.i_sw_n = 4'hF;
        repeat (10) tick();
        check_eq("t5_ch3_held", bus.o_led, 4'b1000);
        bus.i_clear = 1'b1;
        tick();
        bus.i_clear = 1'b0;
        check_eq("t5_clear_alone", bus.o_led, 4'b0000);

        // 5b: all channels at once
        bus.i_sw_n = 4'h0;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t5_all_press", bus.o_press_pulse, (k == 6) ? 4'hF : 4'h0);
            check_eq("t5_all_led", bus.o_led, (k >= 6) ? 4'hF : 4'h0);
        end
        bus.i_sw_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t5_all_release", bus.o_release_pulse, (k == 6) ? 4'hF : 4'h0);
        end
        check_eq("t5_all_led_held", bus.o_led, 4'hF);

        // 6: long press on ch0 (press pulse after edge 6, long pulse 20 edges later)
        bus.i_sw_n = 4'b1110;
        for (int k = 0; k < 30; k++) begin
            tick();
            check_eq("t6_long_30", bus.o_long_pulse,
                     (LONG_EN && k == 26) ? 4'b0001 : 4'b0000);
        end
        bus.i_sw_n = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            check_eq("t6_long_after_release", bus.o_long_pulse, 4'b0000);
        end
        bus.i_sw_n = 4'b1110;
        for (int k = 0; k < 15; k++) begin
            tick();
            check_eq("t6_long_15", bus.o_long_pulse, 4'b0000);
        end
        bus.i_sw_n = 4'hF;
        for (int k = 0; k < 30; k++) begin
            tick();
            check_eq("t6_short_no_long", bus.o_long_pulse, 4'b0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
